// File: rtl/mnist_pkg.sv
// Shared dimensions for the MNIST binary-network layers.
// Layer-2 pooling sizes are derived from the conv-2 map size with floor division.
package mnist_pkg;

    localparam int L2_MAP_W  = 11;
    localparam int L2_MAP_H  = 11;
    localparam int L2_CH     = 16;
    localparam int L2_POOL_W = L2_MAP_W / 2;
    localparam int L2_POOL_H = L2_MAP_H / 2;

endpackage

// File: rtl/pool2_row_buf.sv
// Holds one row of horizontally pooled vectors for maxpool_layer_2.
// One synchronous write port and one combinational read port share a single address.
module pool2_row_buf #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: no reset on the storage array; every entry is written on an even
    // row before the following odd row reads it, so reset would only add area.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wr_data;
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/maxpool_layer_2.sv
// 2x2 stride-2 binary max pool (4-input OR) over the 11x11x16 conv-2 map, floor pooling.
// Define MAXPOOL2_STATUS_EN to add the pool2_cnt per-frame output counter.
module maxpool_layer_2
    import mnist_pkg::*;
#(
    parameter int IN_W = L2_MAP_W,
    parameter int IN_H = L2_MAP_H,
    parameter int CH   = L2_CH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_in,
    input  logic conv2_in_1,
    input  logic conv2_in_2,
    input  logic conv2_in_3,
    input  logic conv2_in_4,
    input  logic conv2_in_5,
    input  logic conv2_in_6,
    input  logic conv2_in_7,
    input  logic conv2_in_8,
    input  logic conv2_in_9,
    input  logic conv2_in_10,
    input  logic conv2_in_11,
    input  logic conv2_in_12,
    input  logic conv2_in_13,
    input  logic conv2_in_14,
    input  logic conv2_in_15,
    input  logic conv2_in_16,
    output logic pool2_out_1,
    output logic pool2_out_2,
    output logic pool2_out_3,
    output logic pool2_out_4,
    output logic pool2_out_5,
    output logic pool2_out_6,
    output logic pool2_out_7,
    output logic pool2_out_8,
    output logic pool2_out_9,
    output logic pool2_out_10,
    output logic pool2_out_11,
    output logic pool2_out_12,
    output logic pool2_out_13,
    output logic pool2_out_14,
    output logic pool2_out_15,
    output logic pool2_out_16,
    output logic valid_out_pool2,
    output logic frame_done
`ifdef MAXPOOL2_STATUS_EN
    ,
    output logic [4:0] pool2_cnt
`endif
);

    localparam int CW = $clog2(IN_W);
    localparam int RW = $clog2(IN_H);
    localparam int PW = IN_W / 2;
    localparam int PH = IN_H / 2;
    localparam int AW = (PW > 1) ? $clog2(PW) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CH-1:0] in_vec, h_reg, h, buf_rd, pool_q;
    logic          last_col, last_row, row_in_range, buf_wr, emit;

    assign in_vec = {conv2_in_16, conv2_in_15, conv2_in_14, conv2_in_13,
                     conv2_in_12, conv2_in_11, conv2_in_10, conv2_in_9,
                     conv2_in_8,  conv2_in_7,  conv2_in_6,  conv2_in_5,
                     conv2_in_4,  conv2_in_3,  conv2_in_2,  conv2_in_1};

    assign last_col     = (int'(col) == IN_W - 1);
    assign last_row     = (int'(row) == IN_H - 1);
    // An odd column always has a partner; only the even last row of an odd-height map is dropped.
    assign row_in_range = (int'(row) < 2 * PH);
    assign h            = h_reg | in_vec;
    assign buf_wr       = valid_in & col[0] & ~row[0] & row_in_range;
    assign emit         = valid_in & col[0] & row[0];

    pool2_row_buf #(
        .DEPTH (PW),
        .WIDTH (CH),
        .AW    (AW)
    ) u_row_buf (
        .clk     (clk),
        .wr_en   (buf_wr),
        .addr    (AW'(col >> 1)),
        .wr_data (h),
        .rd_data (buf_rd)
    );

    // NOTE: every register here uses <=, so all reads in this block see the
    // pre-edge values of col/row/h_reg regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col             <= '0;
            row             <= '0;
            h_reg           <= '0;
            pool_q          <= '0;
            valid_out_pool2 <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            valid_out_pool2 <= emit;
            frame_done      <= valid_in & last_col & last_row;
            if (valid_in) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0]) h_reg <= in_vec;
            end
            if (emit) pool_q <= buf_rd | h;
        end
    end

    assign {pool2_out_16, pool2_out_15, pool2_out_14, pool2_out_13,
            pool2_out_12, pool2_out_11, pool2_out_10, pool2_out_9,
            pool2_out_8,  pool2_out_7,  pool2_out_6,  pool2_out_5,
            pool2_out_4,  pool2_out_3,  pool2_out_2,  pool2_out_1} = pool_q;

`ifdef MAXPOOL2_STATUS_EN
    // Count holds through frame_done so the consumer can read the final total.
    always_ff @(posedge clk) begin
        if (!rst_n)          pool2_cnt <= '0;
        else if (frame_done) pool2_cnt <= '0;
        else if (emit)       pool2_cnt <= pool2_cnt + 1'b1;
    end
`endif

endmodule
